// File: rtl/triangle_assembler_pkg.sv
// Shared render-pipeline package: pixel/depth widths and assembler state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Used by vertex post-processing, the triangle assembler and the rasterizer so
// that coordinate and depth widths agree across the pipeline.
package triangle_assembler_pkg;

  // Signed screen-coordinate width produced by vertex post-processing.
  localparam int PIX_W   = 12;
  // Unsigned Q0.12 depth width.
  localparam int DEPTH_W = 12;

  // Width of a doubled signed triangle area for w-bit signed coordinates:
  // differences need w+1 bits, products 2w+2, and their difference 2w+3.
  function automatic int area2_width(input int w);
    return 2 * w + 3;
  endfunction

  typedef enum logic [1:0] {
    TA_COLLECT = 2'd0,
    TA_AREA    = 2'd1,
    TA_DECIDE  = 2'd2,
    TA_OUTPUT  = 2'd3
  } triangle_assembler_state_t;

endpackage

// File: rtl/triangle_assembler_edge_function.sv
// Edge function: twice the signed area of triangle (p0,p1,p2), full precision.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   x0,y0,x1,y1,x2,y2 : signed W-bit vertex coordinates
//   area2             : (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), signed 2W+3 bits
module edge_function
  import triangle_assembler_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic signed [W-1:0]               x0,
  input  logic signed [W-1:0]               y0,
  input  logic signed [W-1:0]               x1,
  input  logic signed [W-1:0]               y1,
  input  logic signed [W-1:0]               x2,
  input  logic signed [W-1:0]               y2,
  output logic signed [area2_width(W)-1:0]  area2
);

  localparam int AW = area2_width(W);

  // Everything is evaluated at the full result width; the true values of the
  // products always fit, so the modular arithmetic below is exact.
  logic signed [AW-1:0] ex0, ey0, ex1, ey1, ex2, ey2;
  logic signed [AW-1:0] dx1, dy1, dx2, dy2;

  always_comb begin
    ex0   = AW'(x0);
    ey0   = AW'(y0);
    ex1   = AW'(x1);
    ey1   = AW'(y1);
    ex2   = AW'(x2);
    ey2   = AW'(y2);
    dx1   = ex1 - ex0;
    dy1   = ey1 - ey0;
    dx2   = ex2 - ex0;
    dy2   = ey2 - ey0;
    area2 = (dx1 * dy2) - (dx2 * dy1);
  end

endmodule

// File: rtl/triangle_assembler.sv
// Groups vertex results into triangles, computes area/bbox, culls or emits them.
// Latency: third vertex sampled at edge k -> o_tri_dv or o_discard from edge k+2.
// Backpressure: o_ready low outside collection; o_tri_dv/data held until i_tri_ready.
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   i_vertex_pixel[2], i_vertex_z, i_vertex_done, i_vertex_invalid : vertex in
//   o_ready                   : vertex may be accepted this cycle
//   i_flush                   : drop any partial/pending triangle
//   o_tri_x/y/z[3], o_tri_area2, o_bb_* : assembled triangle, clamped bbox
//   o_tri_dv, i_tri_ready     : triangle handshake
//   o_discard                 : one-cycle pulse when a triangle is rejected
module triangle_assembler
  import triangle_assembler_pkg::*;
#(
  parameter int OV_DATAWIDTH  = PIX_W,
  parameter int DEPTH_BITS    = DEPTH_W,
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 320,
  parameter int CULL_BACKFACE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [OV_DATAWIDTH-1:0]    i_vertex_pixel [2],
  input  logic        [DEPTH_BITS-1:0]      i_vertex_z,
  input  logic                              i_vertex_done,
  input  logic                              i_vertex_invalid,
  output logic                              o_ready,
  input  logic                              i_flush,
  output logic signed [OV_DATAWIDTH-1:0]    o_tri_x [3],
  output logic signed [OV_DATAWIDTH-1:0]    o_tri_y [3],
  output logic        [DEPTH_BITS-1:0]      o_tri_z [3],
  output logic signed [2*OV_DATAWIDTH+2:0]  o_tri_area2,
  output logic        [OV_DATAWIDTH-1:0]    o_bb_min_x,
  output logic        [OV_DATAWIDTH-1:0]    o_bb_max_x,
  output logic        [OV_DATAWIDTH-1:0]    o_bb_min_y,
  output logic        [OV_DATAWIDTH-1:0]    o_bb_max_y,
  output logic                              o_tri_dv,
  input  logic                              i_tri_ready,
  output logic                              o_discard
);

  localparam int W  = OV_DATAWIDTH;
  localparam int AW = area2_width(W);
  localparam logic signed [W-1:0] X_MAX = W'(WIDTH - 1);
  localparam logic signed [W-1:0] Y_MAX = W'(HEIGHT - 1);

  triangle_assembler_state_t state, state_nxt;

  logic [1:0]           cnt;
  logic                 sticky_invalid;
  logic signed [AW-1:0] area_comb;
  logic signed [W-1:0]  bb_min_x, bb_max_x, bb_min_y, bb_max_y;
  logic                 reject;

  function automatic logic signed [W-1:0] min3(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic signed [W-1:0] c);
    logic signed [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] max3(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b,
                                               input logic signed [W-1:0] c);
    logic signed [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic signed [W-1:0] clamp_px(input logic signed [W-1:0] v,
                                                   input logic signed [W-1:0] hi);
    if (v[W-1])     return '0;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Vertex slots are the output registers themselves: nothing can overwrite
  // them outside collection, so they are naturally stable while presenting.
  edge_function #(.W(W)) u_edge (
    .x0    (o_tri_x[0]),
    .y0    (o_tri_y[0]),
    .x1    (o_tri_x[1]),
    .y1    (o_tri_y[1]),
    .x2    (o_tri_x[2]),
    .y2    (o_tri_y[2]),
    .area2 (area_comb)
  );

  // Evaluated in TA_DECIDE against the raw (unclamped) bbox registered in TA_AREA.
  always_comb begin
    reject = sticky_invalid
          || (o_tri_area2 == '0)
          || ((CULL_BACKFACE != 0) && o_tri_area2[AW-1])
          || bb_max_x[W-1]
          || (bb_min_x > X_MAX)
          || bb_max_y[W-1]
          || (bb_min_y > Y_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TA_COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_tri_dv  = 1'b0;
    case (state)
      TA_COLLECT: begin
        o_ready = 1'b1;
        if (i_vertex_done && (cnt == 2'd2)) state_nxt = TA_AREA;
      end
      TA_AREA:   state_nxt = TA_DECIDE;
      TA_DECIDE: state_nxt = reject ? TA_COLLECT : TA_OUTPUT;
      TA_OUTPUT: begin
        o_tri_dv = 1'b1;
        if (i_tri_ready) state_nxt = TA_COLLECT;
      end
      default:   state_nxt = TA_COLLECT;
    endcase
    // Flush overrides everything, including a same-cycle vertex or transfer.
    if (i_flush) state_nxt = TA_COLLECT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      sticky_invalid <= 1'b0;
      o_discard      <= 1'b0;
      o_tri_area2    <= '0;
      bb_min_x       <= '0;
      bb_max_x       <= '0;
      bb_min_y       <= '0;
      bb_max_y       <= '0;
      for (int i = 0; i < 3; i++) begin
        o_tri_x[i] <= '0;
        o_tri_y[i] <= '0;
        o_tri_z[i] <= '0;
      end
    end else begin
      o_discard <= 1'b0;
      if (i_flush) begin
        cnt            <= '0;
        sticky_invalid <= 1'b0;
      end else begin
        case (state)
          TA_COLLECT: begin
            // Invalid vertices still consume a slot so later triangles stay aligned.
            if (i_vertex_done) begin
              o_tri_x[cnt]   <= i_vertex_pixel[0];
              o_tri_y[cnt]   <= i_vertex_pixel[1];
              o_tri_z[cnt]   <= i_vertex_z;
              sticky_invalid <= sticky_invalid | i_vertex_invalid;
              cnt            <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
            end
          end
          TA_AREA: begin
            o_tri_area2 <= area_comb;
            bb_min_x    <= min3(o_tri_x[0], o_tri_x[1], o_tri_x[2]);
            bb_max_x    <= max3(o_tri_x[0], o_tri_x[1], o_tri_x[2]);
            bb_min_y    <= min3(o_tri_y[0], o_tri_y[1], o_tri_y[2]);
            bb_max_y    <= max3(o_tri_y[0], o_tri_y[1], o_tri_y[2]);
          end
          TA_DECIDE: begin
            sticky_invalid <= 1'b0;
            if (reject) begin
              o_discard <= 1'b1;
            end else begin
              bb_min_x <= clamp_px(bb_min_x, X_MAX);
              bb_max_x <= clamp_px(bb_max_x, X_MAX);
              bb_min_y <= clamp_px(bb_min_y, Y_MAX);
              bb_max_y <= clamp_px(bb_max_y, Y_MAX);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_bb_min_x = bb_min_x;
  assign o_bb_max_x = bb_max_x;
  assign o_bb_min_y = bb_min_y;
  assign o_bb_max_y = bb_max_y;

endmodule

// File: tb/tb_triangle_assembler.sv
// Bench for triangle_assembler: table of triangles plus stall/flush/reset sequences.
// Latency: checks outputs two edges after the third vertex.
// Backpressure: exercises i_tri_ready stalls and o_ready gating.
module tb_triangle_assembler;

  localparam int W  = 12;
  localparam int DB = 12;
  localparam int AW = 2 * W + 3;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [W-1:0] vpix [2];
  logic [DB-1:0]       vz;
  logic                vdone, vinv, flush, tri_ready, tri_ready1;

  logic                rdy0, dv0, disc0;
  logic signed [W-1:0] tx0 [3], ty0 [3];
  logic [DB-1:0]       tz0 [3];
  logic signed [AW-1:0] area0;
  logic [W-1:0]        bminx0, bmaxx0, bminy0, bmaxy0;

  logic                rdy1, dv1, disc1;
  logic signed [W-1:0] tx1 [3], ty1 [3];
  logic [DB-1:0]       tz1 [3];
  logic signed [AW-1:0] area1;
  logic [W-1:0]        bminx1, bmaxx1, bminy1, bmaxy1;

  triangle_assembler #(.CULL_BACKFACE(1)) dut0 (
    .clk(clk), .rst(rst), .i_vertex_pixel(vpix), .i_vertex_z(vz),
    .i_vertex_done(vdone), .i_vertex_invalid(vinv), .o_ready(rdy0), .i_flush(flush),
    .o_tri_x(tx0), .o_tri_y(ty0), .o_tri_z(tz0), .o_tri_area2(area0),
    .o_bb_min_x(bminx0), .o_bb_max_x(bmaxx0), .o_bb_min_y(bminy0), .o_bb_max_y(bmaxy0),
    .o_tri_dv(dv0), .i_tri_ready(tri_ready), .o_discard(disc0)
  );

  triangle_assembler #(.CULL_BACKFACE(0)) dut1 (
    .clk(clk), .rst(rst), .i_vertex_pixel(vpix), .i_vertex_z(vz),
    .i_vertex_done(vdone), .i_vertex_invalid(vinv), .o_ready(rdy1), .i_flush(flush),
    .o_tri_x(tx1), .o_tri_y(ty1), .o_tri_z(tz1), .o_tri_area2(area1),
    .o_bb_min_x(bminx1), .o_bb_max_x(bmaxx1), .o_bb_min_y(bminy1), .o_bb_max_y(bmaxy1),
    .o_tri_dv(dv1), .i_tri_ready(tri_ready1), .o_discard(disc1)
  );

  typedef struct {
    logic signed [W-1:0]  x [3];
    logic signed [W-1:0]  y [3];
    logic [DB-1:0]        z [3];
    logic [2:0]           inv;
    logic                 exp_discard;
    logic signed [AW-1:0] exp_area;
    logic [W-1:0]         bminx, bmaxx, bminy, bmaxy;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb [$];

  int total = 0;
  int bad   = 0;
  int cnt1  = 0;
  logic signed [AW-1:0] last_area1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i,
                         input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input logic [2:0] inv,
                         input logic disc, input int area,
                         input int bx0, input int bx1, input int by0, input int by1);
    vecs[i].x[0] = W'(x0); vecs[i].y[0] = W'(y0);
    vecs[i].x[1] = W'(x1); vecs[i].y[1] = W'(y1);
    vecs[i].x[2] = W'(x2); vecs[i].y[2] = W'(y2);
    for (int k = 0; k < 3; k++) vecs[i].z[k] = DB'(i * 3 + k + 1);
    vecs[i].inv         = inv;
    vecs[i].exp_discard = disc;
    vecs[i].exp_area    = AW'(area);
    vecs[i].bminx = W'(bx0); vecs[i].bmaxx = W'(bx1);
    vecs[i].bminy = W'(by0); vecs[i].bmaxy = W'(by1);
  endtask

  // Called just after a rising edge; consumes exactly one cycle.
  task automatic send_vtx(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                          input logic [DB-1:0] z, input logic inv, input logic fl);
    chk("ready_before_vtx", {31'd0, rdy0}, 32'd1);
    vpix[0] = x; vpix[1] = y; vz = z; vinv = inv; vdone = 1'b1; flush = fl;
    @(posedge clk); #1;
    vdone = 1'b0; vinv = 1'b0; flush = 1'b0;
  endtask

  task automatic run_tri(input int i, input logic push);
    if (push) sb.push_back(vecs[i]);
    for (int k = 0; k < 3; k++)
      send_vtx(vecs[i].x[k], vecs[i].y[k], vecs[i].z[k], vecs[i].inv[k], 1'b0);
    @(negedge clk); chk("lat_k0_quiet", {31'd0, dv0 | disc0}, 32'd0);
    @(negedge clk); chk("lat_k1_quiet", {31'd0, dv0 | disc0}, 32'd0);
    @(negedge clk); chk("lat_k2_result", {31'd0, dv0 | disc0}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard: every emitted or discarded triangle of dut0 is matched in order.
  always @(negedge clk) begin
    if (!rst && (disc0 || (dv0 && tri_ready))) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output: dv=%0b discard=%0b with empty scoreboard", dv0, disc0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("kind_discard", {31'd0, disc0}, {31'd0, e.exp_discard});
        if (!e.exp_discard) begin
          chk("area2", area0, e.exp_area);
          chk("bb_min_x", bminx0, e.bminx);
          chk("bb_max_x", bmaxx0, e.bmaxx);
          chk("bb_min_y", bminy0, e.bminy);
          chk("bb_max_y", bmaxy0, e.bmaxy);
          for (int k = 0; k < 3; k++) begin
            chk("tri_x", tx0[k], e.x[k]);
            chk("tri_y", ty0[k], e.y[k]);
            chk("tri_z", tz0[k], e.z[k]);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dv1 && tri_ready1) begin
      cnt1++;
      last_area1 = area1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    //        x0   y0   x1   y1   x2   y2   inv   disc area    bbox x      bbox y
    set_vec(0,  10,  10, 100,  10,  10, 100, 3'b000, 0,   8100,  10, 100,  10, 100);
    set_vec(1,  10,  10,  10, 100, 100,  10, 3'b000, 1,  -8100,   0,   0,   0,   0);
    set_vec(2, -20,  -5, 400,  10,  50, 300, 3'b000, 0, 127050,   0, 319,   0, 300);
    set_vec(3,  10,  10, 100,  10,  10, 100, 3'b010, 1,   8100,   0,   0,   0,   0);
    set_vec(4,   0,   0,  50,   0,   0,  60, 3'b000, 0,   3000,   0,  50,   0,  60);
    set_vec(5,   0,   0,  10,  10,  20,  20, 3'b000, 1,      0,   0,   0,   0,   0);
    set_vec(6, 400,  10, 500,  10, 400, 100, 3'b000, 1,   9000,   0,   0,   0,   0);
    set_vec(7,  10,-100, 100,-100,  10, -10, 3'b000, 1,   8100,   0,   0,   0,   0);
    set_vec(8, 319,   0, 330,   0, 319,  10, 3'b000, 0,    110, 319, 319,   0,  10);
    set_vec(9, -10,   0,   0,   0, -10,  10, 3'b000, 0,    100,   0,   0,   0,  10);

    rst = 1'b1; vpix[0] = '0; vpix[1] = '0; vz = '0;
    vdone = 1'b0; vinv = 1'b0; flush = 1'b0; tri_ready = 1'b1; tri_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_dv", {31'd0, dv0}, 32'd0);
    chk("rst_discard", {31'd0, disc0}, 32'd0);
    chk("rst_area", area0, 32'd0);
    chk("rst_bb_max_x", bmaxx0, 32'd0);
    chk("rst_tri_x0", tx0[0], 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      c1 = cnt1;
      run_tri(i, 1'b1);
      if (i == 1) begin
        chk("nocull_emitted", cnt1 - c1, 32'd1);
        chk("nocull_area", last_area1, 32'(AW'(-8100)));
      end
    end

    // Stall: i_tri_ready low for 5 presenting cycles, transfer on the 6th.
    tri_ready = 1'b0;
    run_tri(0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("stall_dv", {31'd0, dv0}, 32'd1);
      chk("stall_ready", {31'd0, rdy0}, 32'd0);
      chk("stall_area", area0, 32'd8100);
      chk("stall_bb_max_y", bmaxy0, 32'd100);
    end
    @(posedge clk); #1 tri_ready = 1'b1;
    @(negedge clk); chk("xfer_dv", {31'd0, dv0}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_xfer_ready", {31'd0, rdy0}, 32'd1);
    chk("post_xfer_dv", {31'd0, dv0}, 32'd0);
    @(posedge clk); #1;

    // Flush with a concurrent vertex, then a plain flush; only the final triple counts.
    send_vtx(12'sd5, 12'sd5, 12'd7, 1'b0, 1'b0);
    send_vtx(12'sd6, 12'sd6, 12'd7, 1'b0, 1'b0);
    send_vtx(12'sd7, 12'sd9, 12'd7, 1'b0, 1'b1);
    send_vtx(12'sd8, 12'sd3, 12'd7, 1'b1, 1'b0);
    flush = 1'b1; @(posedge clk); #1 flush = 1'b0;
    run_tri(4, 1'b1);

    // Reset while presenting drops the triangle immediately with no discard.
    tri_ready = 1'b0;
    run_tri(2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_dv", {31'd0, dv0}, 32'd0);
    chk("rst_out_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_out_discard", {31'd0, disc0}, 32'd0);
    chk("rst_out_area", area0, 32'd0);
    @(posedge clk); #1 rst = 1'b0; tri_ready = 1'b1;
    @(posedge clk); #1;
    run_tri(8, 1'b1);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/triangle_assembler.md
TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have parameter OV_DATAWIDTH, default 12: signed pixel-coordinate width, equal to the post-processor output width.
REQ-002 SHALL have parameter DEPTH_BITS, default 12: unsigned Q0.12 depth width.
REQ-003 SHALL have parameters WIDTH and HEIGHT, default 320 each: screen size in pixels.
REQ-004 SHALL have parameter CULL_BACKFACE, default 1: 1 = discard back-facing triangles.
REQ-005 SHALL have port clk, input, 1: single clock.
REQ-006 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-007 SHALL have port i_vertex_pixel[2], input, OV_DATAWIDTH signed: screen x/y of the incoming vertex.
REQ-008 SHALL have port i_vertex_z, input, DEPTH_BITS: vertex depth.
REQ-009 SHALL have ports i_vertex_done and i_vertex_invalid, input, 1 each: vertex result strobe and its clip-fail flag.
REQ-010 SHALL have port o_ready, output, 1: high only when the block can accept a vertex.
REQ-011 SHALL have port i_flush, input, 1: discards any partial triangle.
REQ-012 SHALL have ports o_tri_x[3], o_tri_y[3] (OV_DATAWIDTH signed) and o_tri_z[3] (DEPTH_BITS), outputs: triangle vertices in arrival order.
REQ-013 SHALL have port o_tri_area2, output, 2*OV_DATAWIDTH+3 signed: twice the signed area.
REQ-014 SHALL have ports o_bb_min_x, o_bb_max_x, o_bb_min_y, o_bb_max_y, output, OV_DATAWIDTH: clamped bounding box.
REQ-015 SHALL have ports o_tri_dv (output), i_tri_ready (input) and o_discard (output), 1 each.

Function
REQ-016 SHALL use states TA_COLLECT, TA_AREA, TA_DECIDE and TA_OUTPUT.
REQ-017 In TA_COLLECT, o_ready=1; each i_vertex_done stores pixel and z in slot cnt, ORs i_vertex_invalid into a sticky flag, and increments cnt (0..2).
REQ-018 A done with cnt=2 SHALL move to TA_AREA and clear cnt to 0.
REQ-019 In TA_AREA (one cycle), the block SHALL register area2 = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), computed full-width with no truncation.
REQ-020 In TA_AREA, the block SHALL register the raw min and max of x and of y.
REQ-021 In TA_DECIDE (one cycle), the triangle SHALL be discarded if any of these hold: the sticky flag is set; area2=0; CULL_BACKFACE=1 and area2<0; max_x<0; min_x>WIDTH-1; max_y<0; min_y>HEIGHT-1.
REQ-022 On discard, o_discard SHALL pulse for 1 cycle and the state SHALL return to TA_COLLECT.
REQ-023 Otherwise the block SHALL clamp the bbox to [0,WIDTH-1] x [0,HEIGHT-1] and enter TA_OUTPUT.
REQ-024 In TA_OUTPUT, o_tri_dv=1 and all o_tri_*/o_bb_* outputs SHALL be held stable until i_tri_ready=1.
REQ-025 When i_tri_ready=1, the transfer completes that cycle, o_tri_dv drops next cycle, and the state returns to TA_COLLECT.
REQ-026 Latency: third done sampled at edge k gives o_tri_dv or o_discard high from edge k+2.
REQ-027 i_vertex_done while o_ready=0 SHALL be ignored; the upstream stage must not issue it.
REQ-028 i_flush, in any state, SHALL go to TA_COLLECT next edge with cnt=0, sticky flag cleared and o_tri_dv=0.
REQ-029 i_flush concurrent with i_vertex_done or i_tri_ready wins: the vertex is dropped and no transfer is counted.
REQ-030 An invalid vertex SHALL still occupy its slot, so triangle boundaries stay aligned.

Reset
REQ-031 While rst=1: state TA_COLLECT, cnt=0, sticky flag=0, o_tri_dv=0, o_discard=0, all data outputs and o_tri_area2=0; o_ready follows state, so it is 1.
REQ-032 Reset asserted mid-triangle or mid-TA_OUTPUT SHALL drop the triangle with no o_discard pulse.

Structure
REQ-033 The state typedef triangle_assembler_state_t SHALL live in the shared render-pipeline package, alongside pixel/depth width constants used by both this block and vertex post-processing.
REQ-034 One sub-module, edge_function, SHALL compute the signed area term and be reused by the rasterizer; min/max/clamp SHALL stay inline.

Verification
REQ-035 Vertices (10,10),(100,10),(10,100), all valid -> o_tri_area2=8100, bbox 10..100 x 10..100, o_tri_dv at k+2.
REQ-036 Same vertices ordered (10,10),(10,100),(100,10) with CULL_BACKFACE=1 -> area2=-8100, o_discard pulse, no o_tri_dv. With CULL_BACKFACE=0 -> triangle emitted.
REQ-037 Vertices (-20,-5),(400,10),(50,300) -> area2=127050, bbox min_x=0, max_x=319, min_y=0, max_y=300.
REQ-038 Second vertex carries i_vertex_invalid=1 -> discard; the next three valid vertices form a clean triangle.
REQ-039 i_tri_ready held low 5 cycles -> o_tri_dv and outputs stable, o_ready=0; transfer on the 6th cycle, o_ready=1 the next cycle.
REQ-040 i_flush after 2 vertices, then 3 new vertices -> only the new triple is emitted; rst during TA_OUTPUT -> o_tri_dv=0 immediately.
